// File: rtl/reset_seq_pkg.sv
// Shared definitions for the push-button reset-combination generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   state_e    - 3-bit FSM state encodings, also exported on the debug port
//   MAX_BTN    - widest button vector the prefix helper can describe
//   prefix_pat - P(k,n): bits [n-1:n-k] set, all others clear
//   max2       - larger of two integers, used for counter sizing
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RES     = 3'd3,
    ST_STRETCH = 3'd4,
    ST_LOCK    = 3'd5
  } state_e;

  localparam int MAX_BTN = 32;

  // Pattern expected after k buttons have been pressed top-down out of n.
  // Callers truncate the result to their own button width.
  function automatic logic [MAX_BTN-1:0] prefix_pat(input int k, input int n);
    logic [MAX_BTN-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_BTN; i++) begin
      if ((i < n) && (i >= n - k)) begin
        p[i] = 1'b1;
      end
    end
    return p;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_btn_debounce.sv
// Single-button conditioner: polarity fix, 2-FF synchroniser, stability debounce.
// Latency: raw-to-level 2 + DEB_CYCLES clk cycles.
// Backpressure: none; level follows the input once it has been stable long enough.
//
// Ports:
//   clk   in  1  system clock
//   reset in  1  asynchronous active-high reset (level returns to released)
//   raw   in  1  asynchronous button pin
//   level out 1  debounced, active-high pressed level
module btn_debounce #(
  parameter int DEB_CYCLES = 50000,
  parameter bit ACT_HIGH   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'((DEB_CYCLES < 1) ? 0 : DEB_CYCLES - 1);

  logic          pressed_w;
  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign pressed_w = ACT_HIGH ? raw : ~raw;

  // The counter only runs while the synchronised value disagrees with the
  // current level; a single agreeing cycle starts the qualification over.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], pressed_w};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/reset_seq_btn.sv
// N-button ordered reset combination: debounce, top-down press order, hold qualification, stretched pulse.
// Latency: 1 clk from debounced levels to state/res/progress (2 + DEB_CYCLES + 1 from raw pins).
// Backpressure: none; res is a free-running registered request to the reset tree.
//
// Ports:
//   clk      in  1               system clock
//   reset    in  1               asynchronous active-high reset
//   btn      in  NBTN            raw asynchronous button inputs
//   res      out 1               registered reset request (1 in RES and STRETCH)
//   state    out 3               current FSM state code (debug/LED)
//   progress out clog2(NBTN+1)   buttons correctly pressed so far
module reset_seq_btn
  import reset_seq_pkg::*;
#(
  parameter int NBTN         = 2,
  parameter int DEB_CYCLES   = 50000,
  parameter int HOLD_CYCLES  = 1000000,
  parameter int PULSE_CYCLES = 16,
  parameter bit BTN_ACT_HIGH = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NBTN-1:0]            btn,
  output logic                       res,
  output logic [2:0]                 state,
  output logic [$clog2(NBTN+1)-1:0]  progress
);

  localparam int PW = $clog2(NBTN + 1);
  localparam int CW = $clog2(max2(HOLD_CYCLES, PULSE_CYCLES) + 1);

  localparam logic [CW-1:0]   HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [NBTN-1:0] P_ONE      = NBTN'(prefix_pat(1, NBTN));
  localparam logic [NBTN-1:0] P_ALL      = NBTN'(prefix_pat(NBTN, NBTN));
  localparam logic [PW-1:0]   K_FULL     = PW'(NBTN);

  logic [NBTN-1:0] deb_w;

  for (genvar gi = 0; gi < NBTN; gi++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .ACT_HIGH   (BTN_ACT_HIGH)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .raw   (btn[gi]),
      .level (deb_w[gi])
    );
  end

  state_e          state_q, state_d;
  logic [PW-1:0]   progress_q, progress_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            res_q, res_d;

  logic [NBTN-1:0] p_cur_w, p_next_w;
  logic            is_zero, is_one, is_all, is_cur, is_next;
  logic [PW-1:0]   k_d;

  // Patterns relative to the current press count: staying put, or exactly one more button.
  always_comb begin
    p_cur_w  = NBTN'(prefix_pat(int'(progress_q), NBTN));
    p_next_w = NBTN'(prefix_pat(int'(progress_q) + 1, NBTN));
    is_zero  = (deb_w == '0);
    is_one   = (deb_w == P_ONE);
    is_all   = (deb_w == P_ALL);
    is_cur   = (deb_w == p_cur_w);
    is_next  = (deb_w == p_next_w);
  end

  always_comb begin
    state_d = state_q;
    k_d     = progress_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (is_one) begin
          // With a single button the first press already completes the combination.
          state_d = (NBTN == 1) ? ST_HOLD : ST_ARM;
          k_d     = PW'(1);
        end else if (!is_zero) begin
          state_d = ST_LOCK;
        end
      end

      ST_ARM: begin
        if (is_cur) begin
          state_d = ST_ARM;
        end else if (is_next) begin
          k_d     = progress_q + PW'(1);
          state_d = (int'(progress_q) + 1 == NBTN) ? ST_HOLD : ST_ARM;
        end else if (is_zero) begin
          state_d = ST_IDLE;
        end else begin
          // Multi-step jumps and partial releases both land here.
          state_d = ST_LOCK;
        end
      end

      ST_HOLD: begin
        if (is_all) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RES;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (is_zero) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCK;
        end
      end

      ST_RES: begin
        if (!is_all) begin
          state_d = ST_STRETCH;
        end
      end

      ST_STRETCH: begin
        // Pulse length is fixed once stretching starts; buttons are ignored until it ends.
        if (cnt_q == PULSE_LAST) begin
          state_d = is_zero ? ST_IDLE : ST_LOCK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_LOCK: begin
        if (is_zero) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every state entry starts the shared counter from zero, so it never wraps.
    if (state_d != state_q) begin
      cnt_d = '0;
    end

    case (state_d)
      ST_ARM:                        progress_d = k_d;
      ST_HOLD, ST_RES, ST_STRETCH:   progress_d = K_FULL;
      default:                       progress_d = '0;
    endcase

    res_d = (state_d == ST_RES) || (state_d == ST_STRETCH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      progress_q <= '0;
      cnt_q      <= '0;
      res_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      progress_q <= progress_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
    end
  end

  assign res      = res_q;
  assign state    = state_q;
  assign progress = progress_q;

endmodule

// File: tb/tb_reset_seq_btn.sv
// Scoreboard bench for reset_seq_btn (NBTN=3, DEB=4, HOLD=8, PULSE=5).
// Stimulus pushes the expected {state,res,progress} change together with the
// clk count at which it must appear; a negedge monitor pops on every output change.
module tb_reset_seq_btn;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RES  = 3'd3;
  localparam logic [2:0] S_STR  = 3'd4;
  localparam logic [2:0] S_LOCK = 3'd5;

  // Pin change to FSM reaction: 2 synchroniser + 4 debounce + 1 state register.
  localparam int LAT = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn;
  logic       res;
  logic [2:0] state;
  logic [1:0] progress;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int         at;
    logic [2:0] st;
    logic       r;
    logic [1:0] pg;
  } exp_t;

  exp_t       q[$];
  logic [5:0] prev = 6'd0;

  reset_seq_btn #(
    .NBTN         (3),
    .DEB_CYCLES   (4),
    .HOLD_CYCLES  (8),
    .PULSE_CYCLES (5),
    .BTN_ACT_HIGH (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .res      (res),
    .state    (state),
    .progress (progress)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observable change must match the next scoreboard entry, at its cycle.
  always @(negedge clk) begin
    logic [5:0] cur;
    exp_t       e;
    cur = {state, res, progress};
    if (cur !== prev) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change cyc=%0d got st=%0d res=%0b prog=%0d", cyc, state, res, progress);
      end else begin
        e = q.pop_front();
        if (cur !== {e.st, e.r, e.pg} || cyc != e.at) begin
          fails++;
          $display("FAIL seq_step got st=%0d res=%0b prog=%0d @cyc %0d, want st=%0d res=%0b prog=%0d @cyc %0d",
                   state, res, progress, cyc, e.st, e.r, e.pg, e.at);
        end
      end
      prev = cur;
    end
  end

  task automatic push(input int at, input logic [2:0] st, input logic r, input logic [1:0] pg);
    exp_t e;
    e.at = at; e.st = st; e.r = r; e.pg = pg;
    q.push_back(e);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Walk the full combination; HOLD entered at t+27, RES at t+35.
  task automatic to_res(input int t, input bit want_res);
    btn = 3'b100; push(t + LAT, S_ARM, 1'b0, 2'd1);
    wait_to(t + 10);
    btn = 3'b110; push(t + 10 + LAT, S_ARM, 1'b0, 2'd2);
    wait_to(t + 20);
    btn = 3'b111; push(t + 20 + LAT, S_HOLD, 1'b0, 2'd3);
    if (want_res) push(t + 20 + LAT + 8, S_RES, 1'b1, 2'd3);
  endtask

  initial begin
    int t;
    reset = 1'b1;
    btn   = 3'b111;

    // 1: reset with all buttons held, then release
    #2;
    chk("t1_reset_now", {2'b0, state, res, progress}, {2'b0, S_IDLE, 1'b0, 2'd0});
    wait_to(2);
    t = cyc; reset = 1'b0; push(t + LAT, S_LOCK, 1'b0, 2'd0);
    wait_to(t + 12);
    t = cyc; btn = 3'b000; push(t + LAT, S_IDLE, 1'b0, 2'd0);
    wait_to(t + 12);

    // 2: valid sequence, res exactly 8 clk after HOLD entry
    t = cyc;
    to_res(t, 1'b1);
    wait_to(t + 40);
    chk("t2_res_held", {7'b0, res}, 8'd1);

    // 3: release everything, 5-cycle stretch then IDLE
    t = cyc; btn = 3'b000;
    push(t + LAT, S_STR, 1'b1, 2'd3);
    push(t + LAT + 5, S_IDLE, 1'b0, 2'd0);
    wait_to(t + 16);

    // 4: wrong order locks until full release
    t = cyc; btn = 3'b001; push(t + LAT, S_LOCK, 1'b0, 2'd0);
    wait_to(t + 10);
    btn = 3'b111;
    wait_to(t + 20);
    chk("t4_still_lock", {5'b0, state}, {5'b0, S_LOCK});
    btn = 3'b000; push(t + 20 + LAT, S_IDLE, 1'b0, 2'd0);
    wait_to(t + 32);

    // 5: 3-cycle glitch rejected; 4-cycle pulse is just long enough
    t = cyc; btn = 3'b100;
    wait_to(t + 3);
    btn = 3'b000;
    wait_to(t + 15);
    chk("t5_glitch_state", {5'b0, state}, {5'b0, S_IDLE});
    chk("t5_glitch_deb", {5'b0, dut.deb_w}, 8'd0);
    t = cyc; btn = 3'b100;
    wait_to(t + 4);
    btn = 3'b000;
    push(t + LAT, S_ARM, 1'b0, 2'd1);
    push(t + LAT + 4, S_IDLE, 1'b0, 2'd0);
    wait_to(t + 16);

    // 6a: two buttons in the same cycle
    t = cyc; btn = 3'b110; push(t + LAT, S_LOCK, 1'b0, 2'd0);
    wait_to(t + 10);
    btn = 3'b000; push(t + 10 + LAT, S_IDLE, 1'b0, 2'd0);
    wait_to(t + 22);

    // partial release from ARM k=2 back to the k=1 pattern locks
    t = cyc; btn = 3'b100; push(t + LAT, S_ARM, 1'b0, 2'd1);
    wait_to(t + 10);
    btn = 3'b110; push(t + 10 + LAT, S_ARM, 1'b0, 2'd2);
    wait_to(t + 20);
    btn = 3'b100; push(t + 20 + LAT, S_LOCK, 1'b0, 2'd0);
    wait_to(t + 30);
    btn = 3'b000; push(t + 30 + LAT, S_IDLE, 1'b0, 2'd0);
    wait_to(t + 42);

    // 6b: async reset mid-HOLD
    t = cyc;
    to_res(t, 1'b0);
    wait_to(t + 30);
    push(t + 30, S_IDLE, 1'b0, 2'd0);
    reset = 1'b1;
    #1;
    chk("t6_hold_async", {2'b0, state, res, progress}, {2'b0, S_IDLE, 1'b0, 2'd0});
    btn = 3'b000;
    wait_to(t + 32);
    reset = 1'b0;
    wait_to(t + 40);
    chk("t6_hold_after", {5'b0, state}, {5'b0, S_IDLE});

    // 6b: async reset mid-STRETCH drops res without a clock edge
    t = cyc;
    to_res(t, 1'b1);
    wait_to(t + 40);
    btn = 3'b000; push(t + 40 + LAT, S_STR, 1'b1, 2'd3);
    wait_to(t + 49);
    chk("t6_res_before", {7'b0, res}, 8'd1);
    push(t + 49, S_IDLE, 1'b0, 2'd0);
    reset = 1'b1;
    #1;
    chk("t6_stretch_async", {2'b0, state, res, progress}, {2'b0, S_IDLE, 1'b0, 2'd0});
    wait_to(t + 51);
    reset = 1'b0;
    wait_to(t + 60);
    chk("t6_stretch_after", {4'b0, state, res}, {4'b0, S_IDLE, 1'b0});

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover got=%0d entries want=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
